// File: rtl/xentry_pkg.sv
// xentry_pkg: memory operation encodings shared by the load/store path and the L1 data cache.
// Latency: n/a (types only).
// Backpressure: n/a.
package xentry_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } memory_operation_size_e;

   typedef enum logic {
      LOAD  = 1'b0,
      STORE = 1'b1
   } memory_operation_e;

endpackage

// File: rtl/dcache_assoc_if.sv
// dcache_assoc_if: pipeline request/response and L2 beat signals of the L1 data cache.
// Latency: n/a (wiring only).
// Backpressure: pipe side via pipe_req_ready; L2 side holds each beat until l2_word_valid.
// Modports: slave = the cache, master = load/store unit plus L2 seen as one requester/responder.
interface dcache_assoc_if #(
   parameter int XLEN = 32
);
   import xentry_pkg::*;

   logic [XLEN-1:0]        pipe_req_address;
   memory_operation_size_e pipe_req_size;
   memory_operation_e      pipe_req_type;
   logic [XLEN-1:0]        pipe_req_wdata;
   logic                   pipe_req_valid;
   logic                   pipe_req_ready;
   logic [XLEN-1:0]        pipe_word;
   logic                   pipe_word_valid;
   logic [XLEN-1:0]        l2_address;
   logic                   l2_access;
   logic                   l2_write;
   logic [XLEN-1:0]        l2_wdata;
   logic [XLEN-1:0]        l2_word;
   logic                   l2_word_valid;

   modport slave (
      input  pipe_req_address, pipe_req_size, pipe_req_type, pipe_req_wdata, pipe_req_valid,
      input  l2_word, l2_word_valid,
      output pipe_req_ready, pipe_word, pipe_word_valid,
      output l2_address, l2_access, l2_write, l2_wdata
   );

   modport master (
      output pipe_req_address, pipe_req_size, pipe_req_type, pipe_req_wdata, pipe_req_valid,
      output l2_word, l2_word_valid,
      input  pipe_req_ready, pipe_word, pipe_word_valid,
      input  l2_address, l2_access, l2_write, l2_wdata
   );
endinterface

// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way set-associative write-back/write-allocate L1 data cache with true LRU.
// Latency: hit = 2 cycles accept-to-pipe_word_valid; miss adds BEATS refill beats (plus BEATS writeback beats if victim dirty).
// Backpressure: one request in flight, pipe_req_ready only in IDLE; each L2 beat is held until l2_word_valid.
// Ports: clk, reset_n (async active-low), bus (dcache_assoc_if.slave: pipe request/response + L2 beats).
// Optional: define DCACHE_PERF_COUNTERS_EN to add saturating perf_hits/perf_misses outputs.
module dcache_assoc
   import xentry_pkg::*;
#(
   parameter int LINE_SIZE  = 16,
   parameter int CACHE_SIZE = 256,
   parameter int WAYS       = 2,
   parameter int XLEN       = 32
) (
   input  logic        clk,
   input  logic        reset_n,
`ifdef DCACHE_PERF_COUNTERS_EN
   output logic [31:0] perf_hits,
   output logic [31:0] perf_misses,
`endif
   dcache_assoc_if.slave bus
);
   localparam int SETS   = CACHE_SIZE / (LINE_SIZE * WAYS);
   localparam int WBYTES = XLEN / 8;
   localparam int BEATS  = LINE_SIZE / WBYTES;
   localparam int OFF_W  = $clog2(LINE_SIZE);
   localparam int SBITS  = $clog2(SETS);
   localparam int IDX_W  = (SETS > 1) ? SBITS : 1;
   localparam int TAG_W  = XLEN - OFF_W - SBITS;
   localparam int LANE_W = $clog2(WBYTES);
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_e;
   state_e state_q, state_d;

   logic [XLEN-1:0]        req_addr_q, req_wdata_q, rdata_q;
   memory_operation_size_e req_size_q;
   memory_operation_e      req_type_q;
   logic                   retry_q;
   logic [WAY_W-1:0]       victim_q;
   logic [BEAT_W-1:0]      beat_q;

   logic [XLEN-1:0]  data_q  [WAYS][SETS][BEATS];
   logic [TAG_W-1:0] tag_q   [WAYS][SETS];
   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYS-1:0]  dirty_q [SETS];
   // Per-way recency age: 0 = most recent, WAYS-1 = LRU once every way has been touched.
   logic [WAY_W-1:0] age_q   [SETS][WAYS];

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [BEAT_W-1:0] beat;
   logic [LANE_W-1:0] lane, sh;
   logic [WBYTES-1:0] be;
   logic [XLEN-1:0]   cur_word, load_data, store_word, wdata_sh, mask, beat_off;
   logic              hit, last_beat, victim_dirty;
   logic [WAY_W-1:0]  hit_way, victim;

   assign idx       = IDX_W'((req_addr_q >> OFF_W) % SETS);
   assign tag       = TAG_W'(req_addr_q >> (OFF_W + SBITS));
   assign beat      = BEAT_W'((req_addr_q >> LANE_W) % BEATS);
   assign lane      = LANE_W'(req_addr_q % WBYTES);
   assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
   assign beat_off  = XLEN'(beat_q) << LANE_W;

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      victim  = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      // LRU way first, then any invalid way overrides it; descending loops leave the lowest index.
      for (int w = WAYS - 1; w >= 0; w--)
         if (age_q[idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid_q[idx][w]) victim = WAY_W'(w);
      victim_dirty = valid_q[idx][victim] && dirty_q[idx][victim];
   end

   // Misaligned HALF/WORD accesses are forced aligned by dropping the low lane bits.
   always_comb begin
      cur_word = data_q[hit_way][idx][beat];
      case (req_size_q)
         BYTE: begin
            sh   = lane;
            be   = WBYTES'(1) << lane;
            mask = XLEN'(8'hFF);
         end
         HALF: begin
            sh   = lane & ~LANE_W'(1);
            be   = WBYTES'(3) << (lane & ~LANE_W'(1));
            mask = XLEN'(16'hFFFF);
         end
         default: begin
            sh   = '0;
            be   = '1;
            mask = '1;
         end
      endcase
      load_data  = (cur_word >> {sh, 3'b000}) & mask;
      wdata_sh   = req_wdata_q << {sh, 3'b000};
      store_word = cur_word;
      for (int b = 0; b < WBYTES; b++)
         if (be[b]) store_word[b*8 +: 8] = wdata_sh[b*8 +: 8];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (bus.pipe_req_valid) state_d = LOOKUP;
         LOOKUP:    state_d = hit ? RESPOND : (victim_dirty ? WRITEBACK : REFILL);
         WRITEBACK: if (bus.l2_word_valid && last_beat) state_d = REFILL;
         REFILL:    if (bus.l2_word_valid && last_beat) state_d = LOOKUP;
         RESPOND:   state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_size_q  <= WORD;
         req_type_q  <= LOAD;
         retry_q     <= 1'b0;
         victim_q    <= '0;
         beat_q      <= '0;
         rdata_q     <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
         end
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (bus.pipe_req_valid) begin
               req_addr_q  <= bus.pipe_req_address;
               req_wdata_q <= bus.pipe_req_wdata;
               req_size_q  <= bus.pipe_req_size;
               req_type_q  <= bus.pipe_req_type;
               retry_q     <= 1'b0;
            end
            LOOKUP: if (hit) begin
               rdata_q <= (req_type_q == STORE) ? '0 : load_data;
               if (req_type_q == STORE) dirty_q[idx][hit_way] <= 1'b1;
               for (int w = 0; w < WAYS; w++) begin
                  if (WAY_W'(w) == hit_way)
                     age_q[idx][w] <= '0;
                  else if (age_q[idx][w] <= age_q[idx][hit_way] && age_q[idx][w] != WAY_W'(WAYS - 1))
                     age_q[idx][w] <= age_q[idx][w] + 1'b1;
               end
            end else begin
               victim_q <= victim;
               beat_q   <= '0;
            end
            WRITEBACK: if (bus.l2_word_valid) beat_q <= last_beat ? '0 : beat_q + 1'b1;
            REFILL: if (bus.l2_word_valid) begin
               beat_q <= last_beat ? '0 : beat_q + 1'b1;
               if (last_beat) begin
                  valid_q[idx][victim_q] <= 1'b1;
                  dirty_q[idx][victim_q] <= 1'b0;
                  retry_q                <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Line storage carries no reset: the valid bits alone decide what is live.
   always_ff @(posedge clk) begin
      if (state_q == LOOKUP && hit && req_type_q == STORE)
         data_q[hit_way][idx][beat] <= store_word;
      if (state_q == REFILL && bus.l2_word_valid) begin
         data_q[victim_q][idx][beat_q] <= bus.l2_word;
         if (last_beat) tag_q[victim_q][idx] <= tag;
      end
   end

   assign bus.pipe_req_ready  = (state_q == IDLE);
   assign bus.pipe_word_valid = (state_q == RESPOND);
   assign bus.pipe_word       = (state_q == RESPOND) ? rdata_q : '0;
   // Beat outputs decode straight from state so they fall with an asynchronous reset.
   assign bus.l2_access  = (state_q == WRITEBACK) || (state_q == REFILL);
   assign bus.l2_write   = (state_q == WRITEBACK);
   assign bus.l2_wdata   = (state_q == WRITEBACK) ? data_q[victim_q][idx][beat_q] : '0;
   assign bus.l2_address = (state_q == WRITEBACK) ?
                              ((XLEN'(tag_q[victim_q][idx]) << (OFF_W + SBITS)) | (XLEN'(idx) << OFF_W) | beat_off) :
                           (state_q == REFILL) ?
                              ((req_addr_q & ~XLEN'(LINE_SIZE - 1)) | beat_off) : '0;

`ifdef DCACHE_PERF_COUNTERS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_hits   <= '0;
         perf_misses <= '0;
      end else if (state_q == LOOKUP) begin
         if (hit && !retry_q && perf_hits != '1) perf_hits <= perf_hits + 1'b1;
         if (!hit && perf_misses != '1) perf_misses <= perf_misses + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: directed plus randomized checks of dcache_assoc against a recency-list cache model and an L2 memory model.
// Latency: n/a (bench).
// Backpressure: L2 responder inserts random and forced stalls on l2_word_valid.
module tb_dcache_assoc;
   import xentry_pkg::*;

   typedef struct packed {
      logic [24:0]  tag;
      logic         dirty;
      logic [127:0] data;
   } line_t;

   logic clk;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] faux [4] = '{32'h01234567, 32'h89ABCDEF, 32'h00112233, 32'h44556677};
   logic [31:0] l2mem [logic [31:0]];
   logic [64:0] l2_log[$];
   logic [64:0] exp_log[$];
   line_t       model_q [8][$];
   bit          l2_stall;

`ifdef DCACHE_PERF_COUNTERS_EN
   logic [31:0] perf_hits, perf_misses;
`endif

   dcache_assoc_if #(.XLEN(32)) bus ();

   dcache_assoc #(.LINE_SIZE(16), .CACHE_SIZE(256), .WAYS(2), .XLEN(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
`ifdef DCACHE_PERF_COUNTERS_EN
      .perf_hits  (perf_hits),
      .perf_misses(perf_misses),
`endif
      .bus        (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      logic [1:0] k;
      k = a[3:2];
      if (l2mem.exists(a)) return l2mem[a];
      return faux[k];
   endfunction

   // L2 responder: decides each beat just after the clock edge; DUT consumes it at the next edge.
   initial begin
      bus.l2_word_valid = 1'b0;
      bus.l2_word       = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.l2_word_valid = 1'b0;
         if (!bus.l2_access) begin
            bus.l2_word_valid = 1'($urandom_range(1));
            bus.l2_word       = $urandom;
         end else if (!l2_stall && $urandom_range(3) != 0) begin
            bus.l2_word_valid = 1'b1;
            if (bus.l2_write) begin
               l2mem[bus.l2_address] = bus.l2_wdata;
               l2_log.push_back({1'b1, bus.l2_address, bus.l2_wdata});
            end else begin
               bus.l2_word = mem_rd(bus.l2_address);
               l2_log.push_back({1'b0, bus.l2_address, 32'h0});
            end
         end
      end
   end

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_access(input logic [31:0] a, input memory_operation_size_e sz,
                               input memory_operation_e ty, input logic [31:0] wd,
                               output logic [31:0] exp_rd, output bit exp_hit);
      int          s, w, ln, pos;
      logic [24:0] t;
      line_t       cur, v;
      logic [31:0] word, la;
      bit          sel;
      s = int'(a[6:4]);
      t = a[31:7];
      w = int'(a[3:2]);
      ln = int'(a[1:0]);
      exp_log.delete();
      pos = -1;
      for (int i = 0; i < model_q[s].size(); i++)
         if (model_q[s][i].tag == t) pos = i;
      exp_hit = (pos >= 0);
      if (exp_hit) begin
         cur = model_q[s][pos];
         model_q[s].delete(pos);
      end else begin
         if (model_q[s].size() == 2) begin
            v = model_q[s].pop_back();
            if (v.dirty)
               for (int k = 0; k < 4; k++) begin
                  la = {v.tag, 3'(s), 2'(k), 2'b00};
                  exp_log.push_back({1'b1, la, v.data[k*32 +: 32]});
               end
         end
         cur.tag = t;
         cur.dirty = 1'b0;
         for (int k = 0; k < 4; k++) begin
            la = {t, 3'(s), 2'(k), 2'b00};
            exp_log.push_back({1'b0, la, 32'h0});
            cur.data[k*32 +: 32] = mem_rd(la);
         end
      end
      word = cur.data[w*32 +: 32];
      if (ty == LOAD) begin
         case (sz)
            BYTE:    exp_rd = (word >> (8 * ln)) & 32'hFF;
            HALF:    exp_rd = (word >> (16 * (ln / 2))) & 32'hFFFF;
            default: exp_rd = word;
         endcase
      end else begin
         exp_rd = 32'h0;
         for (int b = 0; b < 4; b++) begin
            sel = (sz == BYTE) ? (b == ln) : (sz == HALF) ? (b / 2 == ln / 2) : 1'b1;
            if (sel)
               word[b*8 +: 8] = (sz == BYTE) ? wd[7:0] : (sz == HALF) ? wd[(b % 2)*8 +: 8] : wd[b*8 +: 8];
         end
         cur.data[w*32 +: 32] = word;
         cur.dirty = 1'b1;
      end
      model_q[s].push_front(cur);
   endtask

   task automatic start_req(input logic [31:0] a, input memory_operation_size_e sz,
                            input memory_operation_e ty, input logic [31:0] wd, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      bus.pipe_req_address = a;
      bus.pipe_req_size    = sz;
      bus.pipe_req_type    = ty;
      bus.pipe_req_wdata   = wd;
      bus.pipe_req_valid   = 1'b1;
      for (int c = 0; c < 50; c++) begin
         if (bus.pipe_req_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.pipe_req_valid   = 1'b0;
      bus.pipe_req_address = $urandom;
      bus.pipe_req_wdata   = $urandom;
      bus.pipe_req_size    = memory_operation_size_e'($urandom_range(2));
      bus.pipe_req_type    = memory_operation_e'($urandom_range(1));
   endtask

   // Cycle 1 is the cycle after the accept edge; a hit shows pipe_word_valid in cycle 2.
   task automatic wait_resp(output logic [31:0] rd, output int lat, output bit ok, output bit pulse_ok);
      ok = 1'b0;
      lat = 0;
      rd = 'x;
      pulse_ok = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         if (bus.pipe_word_valid) begin
            ok = 1'b1;
            lat = c;
            rd = bus.pipe_word;
            break;
         end
      end
      @(posedge clk);
      #1;
      pulse_ok = !bus.pipe_word_valid && bus.pipe_req_ready;
   endtask

   task automatic compare_result(input string tag, input logic [31:0] rd, input int lat, input bit ok,
                                 input bit pulse_ok, input logic [31:0] exp_rd, input bit exp_hit);
      int n;
      check({tag, " response"}, ok, 1'b1);
      check({tag, " pulse"}, pulse_ok, 1'b1);
      check({tag, " data"}, rd, exp_rd);
      if (exp_hit) check({tag, " hit latency"}, lat, 2);
      check({tag, " l2 beats"}, l2_log.size(), exp_log.size());
      n = (l2_log.size() < exp_log.size()) ? l2_log.size() : exp_log.size();
      for (int i = 0; i < n; i++) check({tag, " l2 beat"}, l2_log[i], exp_log[i]);
   endtask

   task automatic run_req(input string tag, input logic [31:0] a, input memory_operation_size_e sz,
                          input memory_operation_e ty, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
      logic [31:0] exp_rd;
      bit exp_hit, ok, pulse_ok;
      model_access(a, sz, ty, wd, exp_rd, exp_hit);
      l2_log.delete();
      start_req(a, sz, ty, wd, ok);
      check({tag, " accept"}, ok, 1'b1);
      wait_resp(rd, lat, ok, pulse_ok);
      compare_result(tag, rd, lat, ok, pulse_ok, exp_rd, exp_hit);
   endtask

   initial begin
      logic [31:0] rd, hold_addr, exp_rd, a;
      int          lat;
      bit          ok, pulse_ok, exp_hit, stable;
      memory_operation_size_e sz;
      memory_operation_e      ty;

      reset_n = 1'b0;
      l2_stall = 1'b0;
      bus.pipe_req_valid   = 1'b0;
      bus.pipe_req_address = '0;
      bus.pipe_req_size    = WORD;
      bus.pipe_req_type    = LOAD;
      bus.pipe_req_wdata   = '0;
      repeat (3) @(negedge clk);
      check("reset ready", bus.pipe_req_ready, 1'b1);
      check("reset pipe_word_valid", bus.pipe_word_valid, 1'b0);
      check("reset l2_access/write", {bus.l2_access, bus.l2_write}, 2'b00);
      check("reset pipe_word", bus.pipe_word, 32'h0);
      check("reset l2_address/wdata", {bus.l2_address, bus.l2_wdata}, 64'h0);
      reset_n = 1'b1;

      // Cold load then repeat.
      run_req("s1 cold load", 32'hBEEF67BA, WORD, LOAD, 32'h0, rd, lat);
      check("s1 word", rd, 32'h00112233);
      for (int k = 0; k < l2_log.size(); k++)
         check("s1 refill addr", {l2_log[k][64], l2_log[k][63:32]}, {1'b0, 32'hBEEF67B0 + 32'(4 * k)});
      run_req("s1 repeat", 32'hBEEF67BA, WORD, LOAD, 32'h0, rd, lat);
      check("s1 repeat latency", lat, 2);
      check("s1 repeat no l2", l2_log.size(), 0);

      run_req("s2 byte", 32'h000188CF, BYTE, LOAD, 32'h0, rd, lat);
      check("s2 byte value", rd, 32'h00000044);
      run_req("s2 half", 32'h000188CE, HALF, LOAD, 32'h0, rd, lat);
      check("s2 half value", rd, 32'h00004455);
`ifdef DCACHE_PERF_COUNTERS_EN
      check("s6 perf", {perf_misses, perf_hits}, {32'd2, 32'd2});
`endif

      run_req("s3 store byte", 32'hBEEF67B9, BYTE, STORE, 32'h123456AB, rd, lat);
      check("s3 store resp", rd, 32'h0);
      run_req("s3 load", 32'hBEEF67B8, WORD, LOAD, 32'h0, rd, lat);
      check("s3 merged", rd, 32'h0011AB33);

      // Set 3: A, dirty B, touch A, miss C evicts B with writeback.
      run_req("s4 A", 32'h00001030, WORD, LOAD, 32'h0, rd, lat);
      run_req("s4 B store", 32'h00002034, WORD, STORE, 32'hCAFEF00D, rd, lat);
      run_req("s4 A touch", 32'h00001030, WORD, LOAD, 32'h0, rd, lat);
      run_req("s4 C", 32'h00003030, WORD, LOAD, 32'h0, rd, lat);
      check("s4 C beats", l2_log.size(), 8);
      check("s4 wb beat0", l2_log[0], {1'b1, 32'h00002030, 32'h01234567});
      check("s4 wb beat1", l2_log[1], {1'b1, 32'h00002034, 32'hCAFEF00D});
      check("s4 refill beat0", l2_log[4], {1'b0, 32'h00003030, 32'h0});
      run_req("s4 A still hits", 32'h00001030, WORD, LOAD, 32'h0, rd, lat);
      check("s4 A hit latency", lat, 2);
      run_req("s4 B reload", 32'h00002034, WORD, LOAD, 32'h0, rd, lat);
      check("s4 B written back", rd, 32'hCAFEF00D);

      // Stall L2 for 10 cycles mid-refill.
      model_access(32'h00005048, WORD, LOAD, 32'h0, exp_rd, exp_hit);
      l2_log.delete();
      start_req(32'h00005048, WORD, LOAD, 32'h0, ok);
      check("s5 accept", ok, 1'b1);
      for (int c = 0; c < 200 && l2_log.size() < 2; c++) @(negedge clk);
      l2_stall = 1'b1;
      @(posedge clk);
      #2;
      hold_addr = bus.l2_address;
      stable = bus.l2_access;
      repeat (10) begin
         @(posedge clk);
         #2;
         if (!(bus.l2_access && bus.l2_address === hold_addr && !bus.l2_word_valid)) stable = 1'b0;
      end
      check("s5 stall stable", stable, 1'b1);
      l2_stall = 1'b0;
      wait_resp(rd, lat, ok, pulse_ok);
      compare_result("s5 stalled refill", rd, lat, ok, pulse_ok, exp_rd, exp_hit);
      check("s5 value", rd, 32'h00112233);

      // Reset in the middle of a refill.
      run_req("s5 prime", 32'h00006050, WORD, LOAD, 32'h0, rd, lat);
      l2_log.delete();
      start_req(32'h00007060, WORD, LOAD, 32'h0, ok);
      for (int c = 0; c < 200 && l2_log.size() < 2; c++) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("s5 reset l2_access/write", {bus.l2_access, bus.l2_write}, 2'b00);
      check("s5 reset l2_address", bus.l2_address, 32'h0);
      check("s5 reset ready", bus.pipe_req_ready, 1'b1);
      for (int s = 0; s < 8; s++) model_q[s].delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      run_req("s5 post-reset", 32'h00006050, WORD, LOAD, 32'h0, rd, lat);
      check("s5 post-reset miss", l2_log.size(), 4);

      // Randomized traffic over four tags per set to force conflicts and dirty evictions.
      for (int i = 0; i < 300; i++) begin
         a  = (32'($urandom_range(3) + 1) << 7) | (32'($urandom_range(7)) << 4) | 32'($urandom_range(15));
         sz = memory_operation_size_e'($urandom_range(2));
         ty = memory_operation_e'($urandom_range(1));
         run_req("rand", a, sz, ty, $urandom, rd, lat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
- N-way set-associative, write-back, write-allocate L1 data cache.
- Parametrised successor to the direct-mapped dcache. Adds associativity, LRU replacement, stores at BYTE/HALF/WORD size, dirty-line writeback, and an explicit ready handshake on both sides.
- Sits between the pipeline load/store unit and L2. Uses the xentry_pkg memory_operation_e and memory_operation_size_e types.

Parameters:
- LINE_SIZE, 16, bytes per line; power of two, at least XLEN/8.
- CACHE_SIZE, 256, total data bytes; power of two.
- WAYS, 2, associativity; power of two, 1..8. WAYS=1 is direct-mapped.
- XLEN, 32, data/address width in bits.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- pipe_req_address  in  XLEN  byte address
- pipe_req_size  in  memory_operation_size_e  BYTE/HALF/WORD
- pipe_req_type  in  memory_operation_e  LOAD/STORE
- pipe_req_wdata  in  XLEN  store data, right-aligned
- pipe_req_valid  in  1  request present
- pipe_req_ready  out  1  cache can accept a request this cycle
- pipe_word  out  XLEN  load data, right-aligned, zero-extended
- pipe_word_valid  out  1  one-cycle pulse: load data valid or store complete
- l2_address  out  XLEN  word-aligned beat address
- l2_access  out  1  L2 beat request
- l2_write  out  1  1 = writeback beat, 0 = refill beat
- l2_wdata  out  XLEN  writeback data
- l2_word  in  XLEN  refill data
- l2_word_valid  in  1  beat accepted (write) / data valid (read)

Behaviour:
- Geometry:
  - SETS = CACHE_SIZE/(LINE_SIZE*WAYS).
  - BEATS = LINE_SIZE/(XLEN/8).
  - Address split: tag | index[log2 SETS] | offset[log2 LINE_SIZE].
- Reset: asynchronous, active-low.
  - All valid, dirty and LRU bits clear; FSM to IDLE.
  - pipe_req_ready=1; pipe_word_valid, l2_access and l2_write =0; pipe_word, l2_address and l2_wdata =0.
- Handshake:
  - Request accepted when pipe_req_valid && pipe_req_ready.
  - All request fields are registered at acceptance; the pipeline may change them afterwards.
  - pipe_req_ready=1 only in IDLE.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
  - IDLE -> LOOKUP on accept.
  - LOOKUP, hit: perform the access; pipe_word_valid pulses in the next cycle (RESPOND); then back to IDLE. Accept-to-valid latency on a hit = 2 cycles.
  - LOOKUP, miss: select the victim = first invalid way (lowest index), else the LRU way. Victim dirty -> WRITEBACK, else REFILL.
  - WRITEBACK: BEATS beats, ascending from offset 0, l2_write=1. Each beat holds l2_address/l2_wdata until l2_word_valid, then advances. After the last beat -> REFILL.
  - REFILL: BEATS beats, l2_write=0, ascending from offset 0. Write l2_word into the victim line on each l2_word_valid. After the last beat: set valid, clear dirty, write tag -> LOOKUP. The retry is guaranteed to hit.
  - l2_access stays high continuously across WRITEBACK and REFILL beats; it drops in the cycle after the final beat's l2_word_valid.
- Data alignment:
  - BYTE uses offset bits [1:0] as the lane; HALF uses bit [1].
  - Misaligned HALF/WORD: the access is forced aligned by ignoring the low address bits. No exception.
- Store hit: update only the addressed bytes; set dirty. pipe_word = 0 on store responses.
- LRU: true LRU per set, updated on every hit, including the post-refill retry.
- Reset mid-operation: FSM abandons the transfer immediately; all lines invalidated; L2 outputs drop asynchronously.
- l2_word_valid outside WRITEBACK/REFILL is ignored.

Optional Feature:
- Macro: DCACHE_PERF_COUNTERS_EN.
- Enabled: adds output ports perf_hits and perf_misses (32 bits each), cleared by reset.
  - perf_hits increments on a LOOKUP hit that is not a post-refill retry.
  - perf_misses increments on each LOOKUP miss.
  - Both saturate at all-ones.
- Disabled: ports and logic absent; all other behaviour identical.

Test Plan:
Defaults used: WAYS=2 (8 sets); L2 model returns word k of a line as {faux_memory[k]}, with faux_memory[0..3] = 01234567, 89ABCDEF, 00112233, 44556677.
1. Cold load WORD 0xBEEF67BA -> 4 refill beats at l2_address 0xBEEF67B0/B4/B8/BC; pipe_word=00112233.
   Repeat the same load -> hit, no l2_access, pipe_word_valid 2 cycles after accept.
2. Load BYTE 0x000188CF -> pipe_word=00000044. Load HALF 0x000188CE -> pipe_word=00004455.
3. Store BYTE 0xAB to 0xBEEF67B9, then load WORD 0xBEEF67B8 -> 0011AB33. Line marked dirty.
4. Fill set 3 with tags A, B, then touch A, then miss on C:
   - B evicted.
   - If B is dirty: 4 writeback beats with l2_write=1, before 4 refill beats.
   - A still hits afterwards.
5. Hold l2_word_valid low 10 cycles mid-refill -> l2_address and l2_access stable; completion correct.
   Assert reset_n low mid-refill -> outputs clear immediately; a subsequent load misses.
6. Compile with DCACHE_PERF_COUNTERS_EN and run scenarios 1–2 -> perf_misses=2, perf_hits=2.
